// File: rtl/pong_pkg.sv
// pong_pkg: shared types and helpers for the Pong pixel generator.
//   level3_t      - colour as a per-channel "full intensity" triple
//   WHITE/CYAN/BLACK - the fixed object colours
//   region_e      - winning drawing region after priority resolution
//   resolve_region() - priority encoder over the S1 region flags
//   clamp_sub()   - saturating subtract used for the paddle tint
package pong_pkg;

  // One bit per channel: 1 means the channel is driven at LEVEL_MAX.
  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } level3_t;

  localparam level3_t WHITE = 3'b111;
  localparam level3_t CYAN  = 3'b011;
  localparam level3_t BLACK = 3'b000;

  typedef enum logic [2:0] {
    REG_BLACK,
    REG_BORDER,
    REG_BALL,
    REG_PADDLE,
    REG_CENTRE
  } region_e;

  // Highest priority first: border bars, ball, paddles, centre line.
  function automatic region_e resolve_region(input logic border,
                                             input logic ball,
                                             input logic paddle,
                                             input logic centre);
    if (border)      return REG_BORDER;
    else if (ball)   return REG_BALL;
    else if (paddle) return REG_PADDLE;
    else if (centre) return REG_CENTRE;
    else             return REG_BLACK;
  endfunction

  // level - score, saturating at zero.
  function automatic logic [15:0] clamp_sub(input logic [15:0] level,
                                            input logic [15:0] score);
    return (score >= level) ? 16'd0 : (level - score);
  endfunction

endpackage

// File: rtl/pong_flash_ctr.sv
// pong_flash_ctr: per-paddle hit-flash frame counter.
//   i_clk, i_rst_n  - clock and asynchronous active-low reset
//   i_hit           - paddle hit pulse; reloads the counter with FLASH_FRAMES
//   i_frame_start   - frame pulse; counts down while nonzero
//   o_flashing      - high while the counter is nonzero
module pong_flash_ctr #(
  parameter int FLASH_FRAMES = 8,
  parameter int CNT_W        = $clog2(FLASH_FRAMES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hit,
  input  logic i_frame_start,
  output logic o_flashing
);

  logic [CNT_W-1:0] r_count;

  // A hit in the same cycle as a frame start reloads rather than decrements.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_hit) begin
      r_count <= CNT_W'(FLASH_FRAMES);
    end else if (i_frame_start && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_flashing = (r_count != '0);

endmodule

// File: rtl/pong_pattern_gen.sv
// pong_pattern_gen: two-stage pixel colour generator for the Pong display.
//   iVGA_CLK, iRST_n        - pixel clock, asynchronous active-low reset
//   iVGA_X/iVGA_Y           - current pixel coordinate
//   iFrame_Start, iDashed   - frame pulse, dashed centre-line select
//   iBallX/iBallY           - ball centre
//   iPlatX/iPlatY/iPlatH    - flattened paddle top-left corners and heights
//   iScore, iHit            - points conceded and hit pulses per paddle
//   oRed/oGreen/oBlue       - pixel colour, two cycles after the coordinate
//   oValid                  - output is an active pixel of an armed frame
module pong_pattern_gen
  import pong_pkg::*;
#(
  parameter int COORD_W      = 10,
  parameter int COLOR_W      = 10,
  parameter int LEVEL_MAX    = 15,
  parameter int N_PADDLES    = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BORDER       = 5,
  parameter int BALL_R       = 5,
  parameter int PADDLE_W     = 10,
  parameter int SCORE_W      = 5,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                           iVGA_CLK,
  input  logic                           iRST_n,
  input  logic [COORD_W-1:0]             iVGA_X,
  input  logic [COORD_W-1:0]             iVGA_Y,
  input  logic                           iFrame_Start,
  input  logic                           iDashed,
  input  logic [COORD_W-1:0]             iBallX,
  input  logic [COORD_W-1:0]             iBallY,
  input  logic [N_PADDLES*COORD_W-1:0]   iPlatX,
  input  logic [N_PADDLES*COORD_W-1:0]   iPlatY,
  input  logic [N_PADDLES*COORD_W-1:0]   iPlatH,
  input  logic [N_PADDLES*SCORE_W-1:0]   iScore,
  input  logic [N_PADDLES-1:0]           iHit,
  output logic [COLOR_W-1:0]             oRed,
  output logic [COLOR_W-1:0]             oGreen,
  output logic [COLOR_W-1:0]             oBlue,
  output logic                           oValid
);

  // One extra bit so that x+BALL_R, bx+BALL_R, px+W and py+H never wrap.
  localparam int XW = COORD_W + 1;
  localparam logic [XW-1:0]      BR   = XW'(BALL_R);
  localparam logic [XW-1:0]      PW   = XW'(PADDLE_W);
  localparam logic [COLOR_W-1:0] FULL = COLOR_W'(LEVEL_MAX);

  // ---------------- shadow registers ----------------
  logic [COORD_W-1:0]           r_ball_x, r_ball_y;
  logic [N_PADDLES*COORD_W-1:0] r_plat_x, r_plat_y, r_plat_h;
  logic [N_PADDLES*SCORE_W-1:0] r_score;
  logic                         r_dashed;
  logic                         r_armed;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_ball_x <= '0;
      r_ball_y <= '0;
      r_plat_x <= '0;
      r_plat_y <= '0;
      r_plat_h <= '0;
      r_score  <= '0;
      r_dashed <= 1'b0;
      r_armed  <= 1'b0;
    end else if (iFrame_Start) begin
      r_ball_x <= iBallX;
      r_ball_y <= iBallY;
      r_plat_x <= iPlatX;
      r_plat_y <= iPlatY;
      r_plat_h <= iPlatH;
      r_score  <= iScore;
      r_dashed <= iDashed;
      r_armed  <= 1'b1;
    end
  end

  // ---------------- S1: region flags ----------------
  logic [XW-1:0] w_x, w_y, w_bx, w_by;
  assign w_x  = {1'b0, iVGA_X};
  assign w_y  = {1'b0, iVGA_Y};
  assign w_bx = {1'b0, r_ball_x};
  assign w_by = {1'b0, r_ball_y};

  logic w_active, w_border, w_ball, w_centre;
  assign w_active = (w_x < XW'(H_ACTIVE)) && (w_y < XW'(V_ACTIVE));
  assign w_border = (w_y < XW'(BORDER)) || (w_y >= XW'(V_ACTIVE - BORDER));
  assign w_ball   = (w_x + BR > w_bx) && (w_x < w_bx + BR) &&
                    (w_y + BR > w_by) && (w_y < w_by + BR);
  // Dashes are 16 rows long, so y[4] alternates drawn/blank segments.
  assign w_centre = (w_x >= XW'(H_ACTIVE / 2 - 1)) &&
                    (w_x <= XW'(H_ACTIVE / 2 + 1)) &&
                    (!r_dashed || !iVGA_Y[4]);

  logic [N_PADDLES-1:0]         w_pad_hit;
  logic [N_PADDLES-1:0]         w_flashing;
  logic [N_PADDLES*COLOR_W-1:0] w_pad_g;

  genvar gi;
  generate
    for (gi = 0; gi < N_PADDLES; gi++) begin : g_paddle
      logic [XW-1:0] w_px, w_py, w_ph;
      assign w_px = {1'b0, r_plat_x[gi*COORD_W +: COORD_W]};
      assign w_py = {1'b0, r_plat_y[gi*COORD_W +: COORD_W]};
      assign w_ph = {1'b0, r_plat_h[gi*COORD_W +: COORD_W]};

      assign w_pad_hit[gi] = (w_x > w_px) && (w_x < w_px + PW) &&
                             (w_y > w_py) && (w_y < w_py + w_ph);

      assign w_pad_g[gi*COLOR_W +: COLOR_W] =
        COLOR_W'(clamp_sub(16'(LEVEL_MAX), 16'(r_score[gi*SCORE_W +: SCORE_W])));

      pong_flash_ctr #(
        .FLASH_FRAMES(FLASH_FRAMES)
      ) u_flash (
        .i_clk        (iVGA_CLK),
        .i_rst_n      (iRST_n),
        .i_hit        (iHit[gi]),
        .i_frame_start(iFrame_Start),
        .o_flashing   (w_flashing[gi])
      );
    end
  endgenerate

  logic                         r_s1_valid, r_s1_border, r_s1_ball, r_s1_centre;
  logic [N_PADDLES-1:0]         r_s1_pad, r_s1_flash;
  logic [N_PADDLES*COLOR_W-1:0] r_s1_g;

  // Tint and flash state travel with the pixel so a frame-start update
  // cannot change pixels already in flight.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_ball   <= 1'b0;
      r_s1_centre <= 1'b0;
      r_s1_pad    <= '0;
      r_s1_flash  <= '0;
      r_s1_g      <= '0;
    end else begin
      r_s1_valid  <= w_active && r_armed;
      r_s1_border <= w_border;
      r_s1_ball   <= w_ball;
      r_s1_centre <= w_centre;
      r_s1_pad    <= w_pad_hit;
      r_s1_flash  <= w_flashing;
      r_s1_g      <= w_pad_g;
    end
  end

  // ---------------- S2: priority resolve ----------------
  region_e              w_region;
  level3_t              w_lvl;
  logic                 w_sel_flash;
  logic [COLOR_W-1:0]   w_sel_g;
  logic [COLOR_W-1:0]   w_r, w_g, w_b;

  always_comb begin
    w_region    = resolve_region(r_s1_border, r_s1_ball, |r_s1_pad, r_s1_centre);
    w_sel_flash = 1'b0;
    w_sel_g     = '0;
    // Walk downward so the lowest-index overlapping paddle is the last write.
    for (int k = N_PADDLES - 1; k >= 0; k--) begin
      if (r_s1_pad[k]) begin
        w_sel_flash = r_s1_flash[k];
        w_sel_g     = r_s1_g[k*COLOR_W +: COLOR_W];
      end
    end
    case (w_region)
      REG_BORDER, REG_CENTRE: w_lvl = WHITE;
      REG_BALL:               w_lvl = CYAN;
      default:                w_lvl = BLACK;
    endcase
    w_r = w_lvl.r ? FULL : '0;
    w_g = w_lvl.g ? FULL : '0;
    w_b = w_lvl.b ? FULL : '0;
    if (w_region == REG_PADDLE) begin
      w_r = FULL;
      w_g = w_sel_flash ? FULL : w_sel_g;
      w_b = w_sel_flash ? FULL : w_sel_g;
    end
    if (!r_s1_valid) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      oRed   <= '0;
      oGreen <= '0;
      oBlue  <= '0;
      oValid <= 1'b0;
    end else begin
      oRed   <= w_r;
      oGreen <= w_g;
      oBlue  <= w_b;
      oValid <= r_s1_valid;
    end
  end

endmodule

// File: tb/tb_pong_pattern_gen.sv
// Scoreboard bench for pong_pattern_gen: every driven pixel pushes its
// expected colour (from a frame-level model or a fixed constant) into a
// queue; a monitor pops and compares when the pixel is due at the output.
module tb_pong_pattern_gen;

  localparam int CW = 10, COLW = 10, N = 2, SW = 5, FF = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [CW-1:0]   vx, vy;
  logic            fs, dashed;
  logic [CW-1:0]   bx_s, by_s;
  logic [N*CW-1:0] px_f, py_f, ph_f;
  logic [N*SW-1:0] sc_f;
  logic [N-1:0]    hit;
  logic [COLW-1:0] o_r, o_g, o_b;
  logic            o_v;

  // Object state driven onto the DUT inputs.
  int bx, by, dsh;
  int px[N], py[N], ph[N], sc[N];

  always_comb begin
    bx_s   = CW'(bx);
    by_s   = CW'(by);
    dashed = (dsh != 0);
    px_f = '0; py_f = '0; ph_f = '0; sc_f = '0;
    for (int k = 0; k < N; k++) begin
      px_f[k*CW +: CW] = CW'(px[k]);
      py_f[k*CW +: CW] = CW'(py[k]);
      ph_f[k*CW +: CW] = CW'(ph[k]);
      sc_f[k*SW +: SW] = SW'(sc[k]);
    end
  end

  pong_pattern_gen dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iVGA_X(vx), .iVGA_Y(vy),
    .iFrame_Start(fs), .iDashed(dashed), .iBallX(bx_s), .iBallY(by_s),
    .iPlatX(px_f), .iPlatY(py_f), .iPlatH(ph_f), .iScore(sc_f), .iHit(hit),
    .oRed(o_r), .oGreen(o_g), .oBlue(o_b), .oValid(o_v)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int due; int x; int y; bit v; int r; int g; int b;
  } exp_t;
  exp_t q[$];

  // ---------------- reference model ----------------
  // Frame-level view: the latched scene, whether any frame has started,
  // a frame number, and the frame each paddle was last hit in.
  int m_bx, m_by, m_dsh, m_armed, m_frame;
  int m_px[N], m_py[N], m_ph[N], m_sc[N], m_hit_frame[N];

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic void model_reset();
    m_bx = 0; m_by = 0; m_dsh = 0; m_armed = 0; m_frame = 0;
    for (int k = 0; k < N; k++) begin
      m_px[k] = 0; m_py[k] = 0; m_ph[k] = 0; m_sc[k] = 0;
      m_hit_frame[k] = -1000;
    end
  endfunction

  function automatic exp_t model_pixel(input int x, input int y);
    exp_t e;
    e.x = x; e.y = y; e.v = 0; e.r = 0; e.g = 0; e.b = 0; e.due = 0;
    if (m_armed == 0 || x >= 640 || y >= 480) return e;
    e.v = 1;
    if (y < 5 || y >= 475) begin
      e.r = 15; e.g = 15; e.b = 15; return e;
    end
    if (iabs(x - m_bx) < 5 && iabs(y - m_by) < 5) begin
      e.g = 15; e.b = 15; return e;
    end
    for (int k = 0; k < N; k++) begin
      if (x > m_px[k] && x < m_px[k] + 10 && y > m_py[k] && y < m_py[k] + m_ph[k]) begin
        e.r = 15;
        if (m_frame - m_hit_frame[k] < FF) begin
          e.g = 15; e.b = 15;
        end else begin
          e.g = (m_sc[k] >= 15) ? 0 : 15 - m_sc[k];
          e.b = e.g;
        end
        return e;
      end
    end
    if (x >= 319 && x <= 321 && (m_dsh == 0 || ((y / 16) % 2) == 0)) begin
      e.r = 15; e.g = 15; e.b = 15;
    end
    return e;
  endfunction

  // Drive one pixel for one clock. If use_c is set the expected colour is
  // the given constant (valid=1) instead of the model's answer.
  task automatic drive_c(input int x, input int y, input bit f, input logic [N-1:0] h,
                         input bit use_c, input int cr, input int cg, input int cb);
    exp_t e;
    vx = CW'(x); vy = CW'(y); fs = f; hit = h;
    e = model_pixel(x, y);
    if (use_c) begin
      e.v = 1; e.r = cr; e.g = cg; e.b = cb;
    end
    e.due = cyc + 2;
    q.push_back(e);
    if (f) begin
      m_bx = bx; m_by = by; m_dsh = dsh; m_armed = 1; m_frame++;
      for (int k = 0; k < N; k++) begin
        m_px[k] = px[k]; m_py[k] = py[k]; m_ph[k] = ph[k]; m_sc[k] = sc[k];
      end
    end
    for (int k = 0; k < N; k++) if (h[k]) m_hit_frame[k] = m_frame;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int x, input int y, input bit f, input logic [N-1:0] h);
    drive_c(x, y, f, h, 1'b0, 0, 0, 0);
  endtask

  task automatic expect_rgb(input int x, input int y, input int cr, input int cg, input int cb);
    drive_c(x, y, 1'b0, '0, 1'b1, cr, cg, cb);
  endtask

  task automatic frame();
    drive(0, 0, 1'b1, '0);
  endtask

  task automatic chk_zero(input string name);
    checks++;
    if (o_v !== 1'b0 || o_r !== '0 || o_g !== '0 || o_b !== '0) begin
      errors++;
      $display("FAIL %s got v=%0b rgb=(%0d,%0d,%0d) want v=0 rgb=(0,0,0)",
               name, o_v, o_r, o_g, o_b);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        if (o_v !== e.v || o_r !== COLW'(e.r) || o_g !== COLW'(e.g) || o_b !== COLW'(e.b)) begin
          errors++;
          $display("FAIL pix(%0d,%0d) got v=%0b rgb=(%0d,%0d,%0d) want v=%0b rgb=(%0d,%0d,%0d)",
                   e.x, e.y, o_v, o_r, o_g, o_b, e.v, e.r, e.g, e.b);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int x, y, k;
    logic [N-1:0] h;
    bit f;
    vx = '0; vy = '0; fs = 1'b0; hit = '0;
    bx = 0; by = 0; dsh = 0;
    for (int i = 0; i < N; i++) begin px[i] = 0; py[i] = 0; ph[i] = 0; sc[i] = 0; end
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_outputs");
    rst_n = 1'b1;

    // Not armed: black and invalid.
    for (int i = 0; i < 100; i++) drive(10, 2, 1'b0, '0);
    frame();
    expect_rgb(10, 2, 15, 15, 15);
    expect_rgb(10, 477, 15, 15, 15);

    // Ball near x=0: no wrap.
    px[0] = 20; py[0] = 300; ph[0] = 40; sc[0] = 0;
    px[1] = 600; py[1] = 200; ph[1] = 50; sc[1] = 2;
    bx = 3; by = 100;
    frame();
    expect_rgb(0, 100, 0, 15, 15);
    expect_rgb(8, 100, 0, 0, 0);
    expect_rgb(7, 104, 0, 15, 15);
    drive(700, 100, 1'b0, '0);

    // Paddle tint.
    py[0] = 100; sc[0] = 4; bx = 200; by = 300;
    frame();
    expect_rgb(25, 120, 15, 11, 11);
    expect_rgb(20, 120, 0, 0, 0);
    sc[0] = 20;
    frame();
    expect_rgb(25, 120, 15, 0, 0);

    // Mid-frame hit on paddle 1.
    expect_rgb(605, 220, 15, 13, 13);
    drive(100, 250, 1'b0, 2'b10);
    expect_rgb(605, 220, 15, 15, 15);
    for (int n = 1; n <= FF; n++) begin
      frame();
      if (n < FF) expect_rgb(605, 220, 15, 15, 15);
      else        expect_rgb(605, 220, 15, 13, 13);
    end

    // Hit together with a frame start: load wins.
    drive(0, 0, 1'b1, 2'b10);
    expect_rgb(605, 220, 15, 15, 15);
    for (int n = 1; n <= FF; n++) begin
      frame();
      if (n < FF) expect_rgb(605, 220, 15, 15, 15);
      else        expect_rgb(605, 220, 15, 13, 13);
    end

    // Ball moved mid-frame keeps the latched position until the next frame.
    expect_rgb(200, 300, 0, 15, 15);
    bx = 400;
    expect_rgb(200, 300, 0, 15, 15);
    expect_rgb(400, 300, 0, 0, 0);
    frame();
    expect_rgb(400, 300, 0, 15, 15);
    expect_rgb(200, 300, 0, 0, 0);

    // Ball over paddle 0 over centre line.
    bx = 320; by = 150; px[0] = 315; py[0] = 140; ph[0] = 40;
    frame();
    expect_rgb(320, 150, 0, 15, 15);
    expect_rgb(320, 175, 15, 0, 0);
    expect_rgb(321, 250, 15, 15, 15);

    // Dashed centre line with nothing else nearby.
    dsh = 1; bx = 100; by = 300; px[0] = 20; py[0] = 300;
    frame();
    for (int yy = 16; yy < 32; yy++) expect_rgb(320, yy, 0, 0, 0);
    expect_rgb(320, 32, 15, 15, 15);
    expect_rgb(319, 10, 15, 15, 15);
    dsh = 0;
    frame();
    expect_rgb(320, 20, 15, 15, 15);

    // Randomised scene, pixels, frame starts and hits.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        bx = $urandom_range(0, 700); by = $urandom_range(0, 520);
        dsh = $urandom_range(0, 1);
        for (int j = 0; j < N; j++) begin
          px[j] = $urandom_range(0, 700); py[j] = $urandom_range(0, 500);
          ph[j] = $urandom_range(0, 120); sc[j] = $urandom_range(0, 31);
        end
      end
      f = ($urandom_range(0, 149) == 0);
      h = ($urandom_range(0, 99) == 0) ? N'($urandom_range(1, 3)) : '0;
      case ($urandom_range(0, 3))
        0: begin
          x = m_bx + $urandom_range(0, 14) - 7; y = m_by + $urandom_range(0, 14) - 7;
        end
        1: begin
          k = $urandom_range(0, N - 1);
          x = m_px[k] + $urandom_range(0, 12) - 1;
          y = m_py[k] + $urandom_range(0, m_ph[k] + 2) - 1;
        end
        2: begin
          x = $urandom_range(317, 323); y = $urandom_range(0, 490);
        end
        default: begin
          x = $urandom_range(0, 700); y = $urandom_range(0, 520);
        end
      endcase
      if (x < 0) x = 0;
      if (y < 0) y = 0;
      drive(x, y, f, h);
    end

    // Asynchronous reset mid-frame.
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    q.delete();
    model_reset();
    @(posedge clk);
    #1;
    chk_zero("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) drive($urandom_range(0, 639), $urandom_range(0, 479), 1'b0, '0);
    frame();
    expect_rgb(50, 1, 15, 15, 15);
    for (int i = 0; i < 200; i++) drive($urandom_range(0, 700), $urandom_range(0, 520), 1'b0, '0);

    vx = '0; vy = '0; fs = 1'b0; hit = '0;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pong_pattern_gen.md
# pong_pattern_gen

Parametrised, pipelined pixel-colour generator for the Pong display path. It replaces the fixed two-paddle pattern stage that sits between the VGA timing controller and the DAC.
- Renders the borders, ball, N paddles and centre line.
- Latches all object state once per frame, so objects do not tear mid-frame.
- Flashes a paddle for a programmable number of frames after a hit.
- Tints each paddle by points conceded.
- Uses overflow-safe coordinate arithmetic, so objects near x=0 or y=0 render correctly.

## Interface
Parameters:
- COORD_W, 10: width of pixel and object coordinates
- COLOR_W, 10: width of each colour channel
- LEVEL_MAX, 15: full-intensity channel value
- N_PADDLES, 2: number of paddles, 1..4
- H_ACTIVE, 640: active width in pixels
- V_ACTIVE, 480: active height in pixels
- BORDER, 5: height of the top and bottom bars in rows
- BALL_R, 5: ball half-size; the ball is drawn where |x−bx|<BALL_R and |y−by|<BALL_R
- PADDLE_W, 10: paddle width
- SCORE_W, 5: width of each score field
- FLASH_FRAMES, 8: number of frames a paddle flashes after a hit

Ports:
- iVGA_CLK, in, 1: pixel clock
- iRST_n, in, 1: asynchronous active-low reset
- iVGA_X / iVGA_Y, in, COORD_W each: current pixel coordinate
- iFrame_Start, in, 1: one-cycle pulse before the first active pixel of each frame
- iDashed, in, 1: selects a dashed centre line; sampled at frame start
- iBallX / iBallY, in, COORD_W each: ball centre
- iPlatX / iPlatY / iPlatH, in, N_PADDLES*COORD_W each, flattened, paddle k at [k*COORD_W +: COORD_W]: paddle top-left corner and height
- iScore, in, N_PADDLES*SCORE_W: points conceded by paddle k
- iHit, in, N_PADDLES: one-cycle pulse when paddle k hits the ball
- oRed / oGreen / oBlue, out, COLOR_W each: pixel colour
- oValid, out, 1: oRGB corresponds to an active pixel (x<H_ACTIVE, y<V_ACTIVE)

## Operation
- **Shadow registers.** All iBall*, iPlat*, iScore and iDashed values are captured into shadow registers on iFrame_Start. All drawing uses only the shadow values.
- **Arming.** An `armed` flag is cleared by reset and set by the first iFrame_Start. While it is clear, the output is black and oValid=0.
- **Flash counters.** There is one counter per paddle, ceil(log2(FLASH_FRAMES+1)) bits wide.
  - iHit[k] loads the counter with FLASH_FRAMES.
  - Otherwise the counter decrements on iFrame_Start when it is nonzero.
  - If iHit[k] and iFrame_Start arrive in the same cycle, the load wins.
  - Paddle k is flashing while its counter is nonzero.
- **Comparisons.** All are done in COORD_W+1 bits, with no modular wrap.
  - Ball: x+BALL_R > bx, x < bx+BALL_R, and the same for y.
  - Paddle: x > px, x < px+PADDLE_W, y > py, y < py+pH.
- **Drawing priority, highest first.** For y in [BORDER, V_ACTIVE−BORDER), evaluate in this order:
  1. Ball: cyan (0, LEVEL_MAX, LEVEL_MAX).
  2. Paddle k, lowest k first. A flashing paddle is white. Otherwise it is (LEVEL_MAX, g, g), with g = LEVEL_MAX − score_k, clamped to 0 when score_k ≥ LEVEL_MAX.
  3. Centre line at x in [H_ACTIVE/2−1, H_ACTIVE/2+1]: white. In dashed mode it is drawn only when y[4]=0.
  4. Otherwise black.
- **Borders and outside area.**
  - y < BORDER: white.
  - y in [V_ACTIVE−BORDER, V_ACTIVE): white.
  - Outside the active area: black, with oValid=0.
- Channels hold values 0..LEVEL_MAX, zero-extended to COLOR_W.

## Timing
- **Reset.** Reset clears all outputs, oValid, shadow registers, flash counters, `armed` and pipeline registers to 0, immediately and asynchronously. Reset mid-frame gives black output until the next iFrame_Start.
- **Pipeline.** There are two stages.
  - S1 registers the region and hit flags, together with the x/y-derived border, centre-line and active flags.
  - S2 resolves priority and registers oRGB and oValid.
  - Latency is exactly 2 cycles from iVGA_X/Y to the output. Throughput is one pixel per clock with no stalls.
- **Shadow update.** Shadow values update on the cycle after iFrame_Start and apply to pixels presented from that cycle onward. Any pixel still in the pipeline completes with its S1 flags.
- **Flash lifetime.** A hit during frame F flashes the paddle for the remainder of F and for frames F+1..F+FLASH_FRAMES−1; it stops at the FLASH_FRAMES-th subsequent iFrame_Start. A hit during an active flash restarts the count.

## Structure
- The package `pong_pkg` holds:
  - the colour constants WHITE, CYAN and BLACK, as level triples;
  - the priority encoding of the region flags;
  - the function `clamp_sub(level, score)`.
- Sub-module `pong_flash_ctr` contains one flash counter plus its load/decrement logic. The top level instantiates it N_PADDLES times in a generate loop.
- The top level holds the shadow registers, `armed`, S1 and S2.

## Test plan
- Reset, then no iFrame_Start for 100 clocks: outputs stay 0 and oValid stays 0. Pulse iFrame_Start, then drive x=10, y=2: two cycles later, RGB=(15,15,15) and oValid=1.
- Ball at (3,100), frame start, then x=0, y=100: cyan two cycles later. Then x=8, y=100: black. This checks that there is no underflow wrap.
- Paddle 0 at (20,100) with H=40 and score 4, frame start, then pixel (25,120): RGB=(15,11,11). With score 20: RGB=(15,0,0).
- Pulse iHit[1] mid-frame, with paddle 1 at (600,200), H=50: paddle 1 is white for the rest of the frame and the next 7 frames, and tinted again from the 8th subsequent frame. iHit and iFrame_Start in the same cycle: the counter reads 8.
- Change iBallX mid-frame: pixels in the current frame still show the old position; the new position appears after the next iFrame_Start.
- Ball overlapping paddle 0 and the centre line at x=320: cyan wins. With iDashed=1, x=320 and y=16..31 with no objects present: black.
